// File: rtl/bcd_pkg.sv
// Shared definitions for the serial binary-to-BCD converter: digit width,
// converter state encoding and the digit-count sizing helper.
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } bcd_state_t;

    // Decimal digits needed to show any BIN_WIDTH-bit unsigned value:
    // ceil(width * log10(2)), with log10(2) taken as 0.30103.
    function automatic int digits_needed(input int width);
        longint scaled;
        scaled = longint'(width) * 64'sd30103;
        return int'((scaled + 64'sd99999) / 64'sd100000);
    endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 so that
// the following left shift carries correctly into the next decimal digit.
module bcd_add3_digit
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_in,
    output logic [BCD_DIGIT_W-1:0] digit_out
);

    assign digit_out = (digit_in >= 4'd5) ? (digit_in + 4'd3) : digit_in;

endmodule

// File: rtl/bcd_serial_converter.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock) with
// valid/ready handshakes on both sides.
// Optional feature: define BCD_BLANK_EN to add the BlankMask output, a
// leading-zero mask registered together with BcdDigits.
// ResetN is expected to be released synchronously to Clock by the reset
// generator upstream; here it only asserts asynchronously.
//
// state    | meaning
// ST_IDLE  | ready for a new value, last result held on BcdDigits
// ST_SHIFT | one add-3 and shift per cycle, BIN_WIDTH cycles
// ST_DONE  | result presented with OutValid until OutReady
module bcd_serial_converter
    import bcd_pkg::*;
#(
    parameter int BIN_WIDTH = 16,
    parameter int DIGITS    = 5
) (
    input  logic                          Clock,
    input  logic                          ResetN,
    input  logic                          InValid,
    output logic                          InReady,
    input  logic [BIN_WIDTH-1:0]          BinaryValue,
    output logic                          OutValid,
    input  logic                          OutReady,
    output logic [BCD_DIGIT_W*DIGITS-1:0] BcdDigits,
    output logic                          Busy
`ifdef BCD_BLANK_EN
    ,
    output logic [DIGITS-1:0]             BlankMask
`endif
);

    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_WIDTH - 1);

    if (DIGITS < digits_needed(BIN_WIDTH)) begin : g_digits_check
        $error("bcd_serial_converter: DIGITS too small for BIN_WIDTH");
    end

    bcd_state_t           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIN_WIDTH-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]     bcd_q, bcd_d;
    logic [BCD_W-1:0]     digits_q, digits_d;

    logic [BCD_W-1:0]     bcd_adj;
    logic [BCD_W-1:0]     bcd_shl;
    logic [BIN_WIDTH-1:0] bin_shl;

    // Add-3 correction on every digit of the accumulator in parallel.
    for (genvar k = 0; k < DIGITS; k++) begin : g_add3
        bcd_add3_digit u_add3 (
            .digit_in  (bcd_q[BCD_DIGIT_W*k +: BCD_DIGIT_W]),
            .digit_out (bcd_adj[BCD_DIGIT_W*k +: BCD_DIGIT_W])
        );
    end

    // The corrected accumulator and the binary shift register move left as one word.
    assign {bcd_shl, bin_shl} = {bcd_adj, bin_q} << 1;

`ifdef BCD_BLANK_EN
    logic [DIGITS-1:0] blank_q, blank_d;
    logic [DIGITS-1:0] blank_next;
    logic              upper_zero;

    // Leading-zero mask of the finished result; units digit never blanks.
    always_comb begin
        blank_next = '0;
        upper_zero = 1'b1;
        for (int k = DIGITS - 1; k > 0; k--) begin
            upper_zero    = upper_zero & (bcd_shl[BCD_DIGIT_W*k +: BCD_DIGIT_W] == 4'd0);
            blank_next[k] = upper_zero;
        end
    end
`endif

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bin_d    = bin_q;
        bcd_d    = bcd_q;
        digits_d = digits_q;
`ifdef BCD_BLANK_EN
        blank_d  = blank_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (InValid) begin
                    bin_d   = BinaryValue;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                bin_d = bin_shl;
                bcd_d = bcd_shl;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d  = ST_DONE;
                    digits_d = bcd_shl;
`ifdef BCD_BLANK_EN
                    blank_d  = blank_next;
`endif
                end
            end
            ST_DONE: begin
                if (OutReady) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter and datapath registers.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            bin_q    <= '0;
            bcd_q    <= '0;
            digits_q <= '0;
`ifdef BCD_BLANK_EN
            blank_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bin_q    <= bin_d;
            bcd_q    <= bcd_d;
            digits_q <= digits_d;
`ifdef BCD_BLANK_EN
            blank_q  <= blank_d;
`endif
        end
    end

    assign InReady   = (state_q == ST_IDLE);
    assign Busy      = (state_q == ST_SHIFT);
    assign OutValid  = (state_q == ST_DONE);
    assign BcdDigits = digits_q;
`ifdef BCD_BLANK_EN
    assign BlankMask = blank_q;
`endif

endmodule

// File: tb/tb_bcd_serial_converter.sv
// Self-checking bench for bcd_serial_converter: a 16-bit/5-digit instance and
// an 8-bit/3-digit instance against a divide/modulo decimal reference model.
module tb_bcd_serial_converter;

    logic clk = 1'b0;
    logic rst_n;

    logic        iv16, ir16, ov16, or16, busy16;
    logic [15:0] bin16;
    logic [19:0] d16;
    logic        iv8, ir8, ov8, or8, busy8;
    logic [7:0]  bin8;
    logic [11:0] d8;
`ifdef BCD_BLANK_EN
    logic [4:0]  blank16;
    logic [2:0]  blank8;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bcd_serial_converter #(.BIN_WIDTH(16), .DIGITS(5)) dut16 (
        .Clock       (clk),
        .ResetN      (rst_n),
        .InValid     (iv16),
        .InReady     (ir16),
        .BinaryValue (bin16),
        .OutValid    (ov16),
        .OutReady    (or16),
        .BcdDigits   (d16),
        .Busy        (busy16)
`ifdef BCD_BLANK_EN
        ,
        .BlankMask   (blank16)
`endif
    );

    bcd_serial_converter #(.BIN_WIDTH(8), .DIGITS(3)) dut8 (
        .Clock       (clk),
        .ResetN      (rst_n),
        .InValid     (iv8),
        .InReady     (ir8),
        .BinaryValue (bin8),
        .OutValid    (ov8),
        .OutReady    (or8),
        .BcdDigits   (d8),
        .Busy        (busy8)
`ifdef BCD_BLANK_EN
        ,
        .BlankMask   (blank8)
`endif
    );

    // Reference: digit k is (v / 10^k) mod 10.
    function automatic logic [19:0] ref_bcd(input int v, input int ndig);
        logic [19:0] r;
        int p;
        r = '0;
        p = 1;
        for (int k = 0; k < ndig; k++) begin
            r[4*k +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    // Reference: bit k set when the value has no more than k decimal digits (k>0).
    function automatic logic [4:0] ref_blank(input int v, input int ndig);
        logic [4:0] m;
        int nd;
        int t;
        nd = 1;
        t = v / 10;
        while (t > 0) begin
            nd++;
            t = t / 10;
        end
        m = '0;
        for (int k = 1; k < ndig; k++) m[k] = (k >= nd);
        return m;
    endfunction

    task automatic start16(input logic [15:0] v, output int lat);
        int n;
        @(negedge clk);
        bin16 = v;
        iv16  = 1'b1;
        n = 0;
        while (!ir16 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        iv16 = 1'b0;
        lat = 0;
        while (!ov16 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic finish16();
        @(negedge clk);
        or16 = 1'b1;
        @(posedge clk);
        #1;
        or16 = 1'b0;
    endtask

    task automatic run8(input logic [7:0] v, output logic [11:0] dig, output int lat);
        int n;
        @(negedge clk);
        bin8 = v;
        iv8  = 1'b1;
        n = 0;
        while (!ir8 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        iv8 = 1'b0;
        lat = 0;
        while (!ov8 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        dig = d8;
        @(negedge clk);
        or8 = 1'b1;
        @(posedge clk);
        #1;
        or8 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (ir16 !== 1'b1 || ov16 !== 1'b0 || busy16 !== 1'b0 || d16 !== 20'h0) begin
            n_fail++;
            $display("FAIL reset16: ir=%b ov=%b busy=%b digits=%h, required 1 0 0 00000", ir16, ov16, busy16, d16);
        end
        n_checks++;
        if (ir8 !== 1'b1 || ov8 !== 1'b0 || busy8 !== 1'b0 || d8 !== 12'h0) begin
            n_fail++;
            $display("FAIL reset8: ir=%b ov=%b busy=%b digits=%h, required 1 0 0 000", ir8, ov8, busy8, d8);
        end
`ifdef BCD_BLANK_EN
        n_checks++;
        if (blank16 !== 5'b0 || blank8 !== 3'b0) begin
            n_fail++;
            $display("FAIL reset_blank: got %b %b, required 0", blank16, blank8);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (ir16 !== 1'b1 || ov16 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: ir=%b ov=%b, required 1 0", ir16, ov16);
        end
    endtask

    task automatic test_zero();
        int lat;
        start16(16'd0, lat);
        n_checks++;
        if (lat !== 16) begin
            n_fail++;
            $display("FAIL zero_latency: got %0d cycles, required 16", lat);
        end
        n_checks++;
        if (d16 !== 20'h00000) begin
            n_fail++;
            $display("FAIL zero_digits: got %h, required 00000", d16);
        end
`ifdef BCD_BLANK_EN
        n_checks++;
        if (blank16 !== 5'b11110) begin
            n_fail++;
            $display("FAIL zero_blank: got %b, required 11110", blank16);
        end
`endif
        finish16();
        n_checks++;
        if (ir16 !== 1'b1 || ov16 !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_release: ir=%b ov=%b, required 1 0", ir16, ov16);
        end
    endtask

    task automatic test_extremes();
        int lat;
        start16(16'd65535, lat);
        n_checks++;
        if (d16 !== ref_bcd(65535, 5) || lat !== 16) begin
            n_fail++;
            $display("FAIL max_value: got %h lat %0d, required %h lat 16", d16, lat, ref_bcd(65535, 5));
        end
        finish16();
        start16(16'd9999, lat);
        n_checks++;
        if (d16 !== ref_bcd(9999, 5)) begin
            n_fail++;
            $display("FAIL value_9999: got %h, required %h", d16, ref_bcd(9999, 5));
        end
`ifdef BCD_BLANK_EN
        n_checks++;
        if (blank16 !== ref_blank(9999, 5)) begin
            n_fail++;
            $display("FAIL blank_9999: got %b, required %b", blank16, ref_blank(9999, 5));
        end
`endif
        finish16();
    endtask

    task automatic test_backpressure();
        int lat;
        logic [19:0] exp;
        exp = ref_bcd(1234, 5);
        start16(16'd1234, lat);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (d16 !== exp || ir16 !== 1'b0 || ov16 !== 1'b1) begin
                n_fail++;
                $display("FAIL backpressure_hold c%0d: digits=%h ir=%b ov=%b, required %h 0 1", c, d16, ir16, ov16, exp);
            end
        end
        finish16();
        n_checks++;
        if (ir16 !== 1'b1 || ov16 !== 1'b0 || d16 !== exp) begin
            n_fail++;
            $display("FAIL backpressure_release: ir=%b ov=%b digits=%h, required 1 0 %h", ir16, ov16, d16, exp);
        end
    endtask

    task automatic test_reset_mid_shift();
        int lat;
        int pulses;
        @(negedge clk);
        bin16 = 16'd4321;
        iv16  = 1'b1;
        @(posedge clk);
        #1;
        iv16 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (busy16 !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_shift_busy: got %b, required 1", busy16);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy16 !== 1'b0 || ir16 !== 1'b1 || ov16 !== 1'b0 || d16 !== 20'h0) begin
            n_fail++;
            $display("FAIL mid_shift_reset: busy=%b ir=%b ov=%b digits=%h, required 0 1 0 00000", busy16, ir16, ov16, d16);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (ov16) pulses++;
        end
        n_checks++;
        if (pulses !== 0) begin
            n_fail++;
            $display("FAIL discarded_result: OutValid high %0d cycles, required 0", pulses);
        end
        start16(16'd42, lat);
        n_checks++;
        if (d16 !== ref_bcd(42, 5) || lat !== 16) begin
            n_fail++;
            $display("FAIL after_reset_42: got %h lat %0d, required %h lat 16", d16, lat, ref_bcd(42, 5));
        end
        finish16();
    endtask

    task automatic test_random16();
        int lat;
        int hold;
        logic [15:0] v;
        for (int i = 0; i < 30; i++) begin
            v = 16'($urandom);
            hold = int'($urandom_range(0, 3));
            start16(v, lat);
            repeat (hold) @(posedge clk);
            #1;
            n_checks++;
            if (d16 !== ref_bcd(int'(v), 5) || lat !== 16 || ov16 !== 1'b1) begin
                n_fail++;
                $display("FAIL random16 v=%0d: got %h lat %0d ov %b, required %h lat 16 ov 1", v, d16, lat, ov16, ref_bcd(int'(v), 5));
            end
`ifdef BCD_BLANK_EN
            n_checks++;
            if (blank16 !== ref_blank(int'(v), 5)) begin
                n_fail++;
                $display("FAIL random16_blank v=%0d: got %b, required %b", v, blank16, ref_blank(int'(v), 5));
            end
`endif
            finish16();
        end
    endtask

    task automatic test_sweep8();
        logic [11:0] dig;
        logic [19:0] exp;
        int lat;
        int bad;
        int order [256];
        int j;
        int t;
        for (int i = 0; i < 256; i++) order[i] = i;
        for (int i = 255; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            t = order[i];
            order[i] = order[j];
            order[j] = t;
        end
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            run8(8'(order[i]), dig, lat);
            exp = ref_bcd(order[i], 3);
            if (dig !== exp[11:0] || lat !== 8) begin
                bad++;
                if (bad < 5) $display("FAIL sweep8 v=%0d: got %h lat %0d, required %h lat 8", order[i], dig, lat, exp[11:0]);
            end
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL sweep8_total: %0d wrong results, required 0", bad);
        end
        run8(8'd255, dig, lat);
        n_checks++;
        if (dig !== 12'h255) begin
            n_fail++;
            $display("FAIL value_255: got %h, required 255", dig);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] q[$];
        logic [15:0] expv;
        int results;
        int last_acc;
        int bad_gap;
        bit acc_now;
        results  = 0;
        last_acc = -1;
        bad_gap  = 0;
        @(negedge clk);
        bin16 = 16'($urandom);
        iv16  = 1'b1;
        or16  = 1'b1;
        for (int cyc = 0; cyc < 8 * 18 + 40; cyc++) begin
            if (cyc != 0) @(negedge clk);
            acc_now = 1'b0;
            if (ov16) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_duplicate: result %h with nothing outstanding", d16);
                end else begin
                    expv = q.pop_front();
                    if (d16 !== ref_bcd(int'(expv), 5)) begin
                        n_fail++;
                        $display("FAIL b2b_result v=%0d: got %h, required %h", expv, d16, ref_bcd(int'(expv), 5));
                    end
                end
                results++;
                if (results == 8) break;
            end
            if (ir16) begin
                q.push_back(bin16);
                if (last_acc >= 0 && cyc - last_acc != 18) bad_gap++;
                last_acc = cyc;
                acc_now = 1'b1;
            end
            @(posedge clk);
            #1;
            if (acc_now) bin16 = 16'($urandom);
        end
        iv16 = 1'b0;
        @(negedge clk);
        or16 = 1'b0;
        n_checks++;
        if (results !== 8 || q.size() !== 0) begin
            n_fail++;
            $display("FAIL b2b_count: %0d results, %0d outstanding, required 8 and 0", results, q.size());
        end
        n_checks++;
        if (bad_gap !== 0) begin
            n_fail++;
            $display("FAIL b2b_interval: %0d accepts not 18 cycles apart, required 0", bad_gap);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        iv16 = 1'b0; or16 = 1'b0; bin16 = '0;
        iv8  = 1'b0; or8  = 1'b0; bin8  = '0;
        test_reset();
        test_zero();
        test_extremes();
        test_backpressure();
        test_reset_mid_shift();
        test_random16();
        test_sweep8();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
